mc_control_unit: RTL and testbench

Parametrised multicycle control FSM for the team's MIPS-subset datapath; successor to the fixed control unit.
- Sequences fetch/decode/execute over a register file, ALU, memory, and an iterative mult/div unit.
- Adds configurable memory wait states, a counted mult/div stall, and exception dispatch (invalid opcode, overflow, divide-by-zero) through EPC.
- Outputs are Moore-decoded from the state register and drive datapath muxes and write enables directly.

---
 rtl/mc_control_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle control FSM for the MIPS-subset datapath.
// Fetch, decode and execute run as Moore states. Each output is registered from the
// decode of the next state, so an output always matches the state shown on state_out.
// Memory wait states and the iterative mult/div latency are counted in dedicated
// counters. Faults go through EXC (save EPC) and EXC_JMP (load the exception vector).
// State encoding (state_out):
//   0 RESET, 1 FETCH, 2 DECODE, 3 EXEC_R, 4 WB_R, 5 EXEC_I, 6 WB_I, 7 MEM_ADDR,
//   8 LW_READ, 9 LW_WB, 10 SW_WRITE, 11 BRANCH, 12 JUMP, 13 JR, 14 MD_START,
//   15 MD_RUN, 16 MD_DONE, 17 EXC, 18 EXC_JMP. Every other code returns to RESET.
module mc_control_unit #(
   parameter int MEM_WAIT  = 1,
   parameter int MD_CYCLES = 32,
   parameter int ST_W      = 5
) (
   input  logic            clk,
   input  logic            resert,
   input  logic [5:0]      opcode,
   input  logic [5:0]      funct,
   input  logic            zero,
   input  logic            overflow,
   input  logic            div0,
   output logic            PCWrite,
   output logic            PCWriteCond,
   output logic            IorD,
   output logic            MemWR,
   output logic            IRWrite,
   output logic            RegWrite,
   output logic            MemToReg,
   output logic            EPCCtrl,
   output logic            MDControl,
   output logic            WriteHI,
   output logic            WriteLO,
   output logic [1:0]      RegDst,
   output logic [1:0]      ALUSrcA,
   output logic [1:0]      ALUSrcB,
   output logic [2:0]      ALUControl,
   output logic [2:0]      PcSource,
   output logic [1:0]      Exception,
   output logic            md_busy,
   output logic [ST_W-1:0] state_out
);

   typedef enum logic [ST_W-1:0] {
      S_RESET    = 5'd0,  S_FETCH    = 5'd1,  S_DECODE  = 5'd2,  S_EXEC_R  = 5'd3,
      S_WB_R     = 5'd4,  S_EXEC_I   = 5'd5,  S_WB_I    = 5'd6,  S_MEM_ADDR = 5'd7,
      S_LW_READ  = 5'd8,  S_LW_WB    = 5'd9,  S_SW_WRITE = 5'd10, S_BRANCH = 5'd11,
      S_JUMP     = 5'd12, S_JR       = 5'd13, S_MD_START = 5'd14, S_MD_RUN = 5'd15,
      S_MD_DONE  = 5'd16, S_EXC      = 5'd17, S_EXC_JMP  = 5'd18
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_wr;
      logic       ir_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic       epc_ctrl;
      logic       md_control;
      logic       write_hi;
      logic       write_lo;
      logic       md_busy;
      logic [1:0] reg_dst;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_ctl;
      logic [2:0] pc_source;
      logic [1:0] exception;
   } ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] F_JR     = 6'h08;
   localparam logic [5:0] F_MULT   = 6'h18;
   localparam logic [5:0] F_DIV    = 6'h1A;
   localparam logic [5:0] F_ADD    = 6'h20;
   localparam logic [5:0] F_SUB    = 6'h22;
   localparam logic [5:0] F_AND    = 6'h24;

   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;

   localparam logic [1:0] EXC_INVALID = 2'b00;
   localparam logic [1:0] EXC_OVF     = 2'b01;
   localparam logic [1:0] EXC_DIV0    = 2'b10;

   localparam int WAIT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
   localparam int MD_W   = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
   localparam logic [MD_W-1:0]   MD_LAST   = MD_W'(MD_CYCLES - 1);
   localparam logic [MD_W-1:0]   MD_ONE    = MD_W'(1);

   state_t             state_r, state_nxt_s;
   logic [WAIT_W-1:0]  wait_cnt_r, wait_nxt_s;
   logic [MD_W-1:0]    md_cnt_r, md_nxt_s;
   logic [1:0]         exc_code_r, exc_nxt_s;
   ctrl_t              ctrl_r;
   logic               unused_zero_s;

   // The branch condition is qualified with zero in the datapath, not here.
   assign unused_zero_s = zero;

   // ALU operation selected by an R-type funct field.
   function automatic logic [2:0] alu_for_funct(input logic [5:0] fn);
      logic [2:0] op;
      case (fn)
         F_SUB:   op = ALU_SUB;
         F_AND:   op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   // Moore decode of one state (plus its wait count) into datapath controls.
   function automatic ctrl_t decode_ctrl(input state_t st, input logic [WAIT_W-1:0] wcnt,
                                         input logic [1:0] exc, input logic [5:0] fn);
      ctrl_t c;
      c = '0;
      case (st)
         S_FETCH: begin
            c.alu_src_b = 2'b01;
            c.alu_ctl   = ALU_ADD;
            if (wcnt == WAIT_LAST) begin
               c.ir_write = 1'b1;
               c.pc_write = 1'b1;
            end else begin
               c.ir_write = 1'b0;
               c.pc_write = 1'b0;
            end
         end
         S_DECODE: begin
            c.alu_src_b = 2'b11;
            c.alu_ctl   = ALU_ADD;
         end
         S_EXEC_R: begin
            c.alu_src_a = 2'b01;
            c.alu_ctl   = alu_for_funct(fn);
         end
         S_WB_R: begin
            c.alu_src_a = 2'b01;
            c.alu_ctl   = alu_for_funct(fn);
            c.reg_dst   = 2'b01;
            c.reg_write = 1'b1;
         end
         S_EXEC_I, S_MEM_ADDR: begin
            c.alu_src_a = 2'b01;
            c.alu_src_b = 2'b10;
            c.alu_ctl   = ALU_ADD;
         end
         S_WB_I: begin
            c.alu_src_a = 2'b01;
            c.alu_src_b = 2'b10;
            c.alu_ctl   = ALU_ADD;
            c.reg_write = 1'b1;
         end
         S_LW_READ:  c.iord = 1'b1;
         S_LW_WB: begin
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
         end
         S_SW_WRITE: begin
            c.iord   = 1'b1;
            c.mem_wr = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a     = 2'b01;
            c.alu_ctl       = ALU_SUB;
            c.pc_source     = 3'b001;
            c.pc_write_cond = 1'b1;
         end
         S_JUMP: begin
            c.pc_source = 3'b010;
            c.pc_write  = 1'b1;
         end
         S_JR: begin
            c.pc_source = 3'b011;
            c.pc_write  = 1'b1;
         end
         S_MD_START: c.md_control = 1'b1;
         S_MD_RUN:   c.md_busy    = 1'b1;
         S_MD_DONE: begin
            c.write_hi = 1'b1;
            c.write_lo = 1'b1;
         end
         S_EXC: begin
            c.epc_ctrl  = 1'b1;
            c.alu_src_b = 2'b01;
            c.alu_ctl   = ALU_SUB;
            c.exception = exc;
         end
         S_EXC_JMP: begin
            c.pc_source = 3'b100;
            c.pc_write  = 1'b1;
            c.exception = exc;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Next-state, wait/MD counter and exception-code logic.
   always_comb begin
      state_nxt_s = state_r;
      wait_nxt_s  = wait_cnt_r;
      md_nxt_s    = md_cnt_r;
      exc_nxt_s   = exc_code_r;
      case (state_r)
         S_RESET: begin
            state_nxt_s = S_FETCH;
            wait_nxt_s  = '0;
            md_nxt_s    = '0;
         end
         S_FETCH: begin
            if (wait_cnt_r == WAIT_LAST) begin
               state_nxt_s = S_DECODE;
               wait_nxt_s  = '0;
            end else begin
               wait_nxt_s  = wait_cnt_r + WAIT_ONE;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_RTYPE: begin
                  case (funct)
                     F_ADD, F_SUB, F_AND: state_nxt_s = S_EXEC_R;
                     F_MULT, F_DIV:       state_nxt_s = S_MD_START;
                     F_JR:                state_nxt_s = S_JR;
                     default: begin
                        state_nxt_s = S_EXC;
                        exc_nxt_s   = EXC_INVALID;
                     end
                  endcase
               end
               OP_ADDI:       state_nxt_s = S_EXEC_I;
               OP_LW, OP_SW:  state_nxt_s = S_MEM_ADDR;
               OP_BEQ, OP_BNE: state_nxt_s = S_BRANCH;
               OP_J:          state_nxt_s = S_JUMP;
               default: begin
                  state_nxt_s = S_EXC;
                  exc_nxt_s   = EXC_INVALID;
               end
            endcase
         end
         S_EXEC_R: begin
            if (overflow && (funct == F_ADD || funct == F_SUB)) begin
               state_nxt_s = S_EXC;
               exc_nxt_s   = EXC_OVF;
            end else begin
               state_nxt_s = S_WB_R;
            end
         end
         S_EXEC_I: begin
            if (overflow) begin
               state_nxt_s = S_EXC;
               exc_nxt_s   = EXC_OVF;
            end else begin
               state_nxt_s = S_WB_I;
            end
         end
         S_MEM_ADDR: begin
            wait_nxt_s = '0;
            if (opcode == OP_LW) begin
               state_nxt_s = S_LW_READ;
            end else begin
               state_nxt_s = S_SW_WRITE;
            end
         end
         S_LW_READ: begin
            if (wait_cnt_r == WAIT_LAST) begin
               state_nxt_s = S_LW_WB;
               wait_nxt_s  = '0;
            end else begin
               wait_nxt_s  = wait_cnt_r + WAIT_ONE;
            end
         end
         S_SW_WRITE: begin
            if (wait_cnt_r == WAIT_LAST) begin
               state_nxt_s = S_FETCH;
               wait_nxt_s  = '0;
            end else begin
               wait_nxt_s  = wait_cnt_r + WAIT_ONE;
            end
         end
         S_MD_START: begin
            md_nxt_s = '0;
            if (funct == F_DIV && div0) begin
               state_nxt_s = S_EXC;
               exc_nxt_s   = EXC_DIV0;
            end else begin
               state_nxt_s = S_MD_RUN;
            end
         end
         S_MD_RUN: begin
            if (md_cnt_r == MD_LAST) begin
               state_nxt_s = S_MD_DONE;
               md_nxt_s    = '0;
            end else begin
               md_nxt_s    = md_cnt_r + MD_ONE;
            end
         end
         S_EXC: state_nxt_s = S_EXC_JMP;
         S_WB_R, S_WB_I, S_LW_WB, S_BRANCH, S_JUMP, S_JR, S_MD_DONE, S_EXC_JMP: begin
            state_nxt_s = S_FETCH;
            wait_nxt_s  = '0;
         end
         default: begin
            state_nxt_s = S_RESET;
            wait_nxt_s  = '0;
            md_nxt_s    = '0;
         end
      endcase
   end

   // State, counters and registered outputs; reset aborts any wait or MD run at once.
   always_ff @(posedge clk or negedge resert) begin
      if (!resert) begin
         state_r    <= S_RESET;
         wait_cnt_r <= '0;
         md_cnt_r   <= '0;
         exc_code_r <= 2'b00;
         ctrl_r     <= '0;
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= wait_nxt_s;
         md_cnt_r   <= md_nxt_s;
         exc_code_r <= exc_nxt_s;
         ctrl_r     <= decode_ctrl(state_nxt_s, wait_nxt_s, exc_nxt_s, funct);
      end
   end

   assign PCWrite     = ctrl_r.pc_write;
   assign PCWriteCond = ctrl_r.pc_write_cond;
   assign IorD        = ctrl_r.iord;
   assign MemWR       = ctrl_r.mem_wr;
   assign IRWrite     = ctrl_r.ir_write;
   assign RegWrite    = ctrl_r.reg_write;
   assign MemToReg    = ctrl_r.mem_to_reg;
   assign EPCCtrl     = ctrl_r.epc_ctrl;
   assign MDControl   = ctrl_r.md_control;
   assign WriteHI     = ctrl_r.write_hi;
   assign WriteLO     = ctrl_r.write_lo;
   assign md_busy     = ctrl_r.md_busy;
   assign RegDst      = ctrl_r.reg_dst;
   assign ALUSrcA     = ctrl_r.alu_src_a;
   assign ALUSrcB     = ctrl_r.alu_src_b;
   assign ALUControl  = ctrl_r.alu_ctl;
   assign PcSource    = ctrl_r.pc_source;
   assign Exception   = ctrl_r.exception;
   assign state_out   = state_r;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed testbench for mc_control_unit. Three instances share all inputs:
// index 0 has MEM_WAIT=1, index 1 has MEM_WAIT=3, index 2 has MEM_WAIT=0 (all MD_CYCLES=32).
module tb_mc_control_unit;

   localparam logic [4:0] ST_RESET = 5'd0,  ST_FETCH  = 5'd1,  ST_DECODE = 5'd2;
   localparam logic [4:0] ST_EXEC_R = 5'd3, ST_WB_R   = 5'd4,  ST_EXEC_I = 5'd5;
   localparam logic [4:0] ST_WB_I  = 5'd6,  ST_MEM_ADDR = 5'd7, ST_LW_READ = 5'd8;
   localparam logic [4:0] ST_LW_WB = 5'd9,  ST_SW_WRITE = 5'd10, ST_BRANCH = 5'd11;
   localparam logic [4:0] ST_JUMP  = 5'd12, ST_JR = 5'd13, ST_MD_START = 5'd14;
   localparam logic [4:0] ST_MD_RUN = 5'd15, ST_MD_DONE = 5'd16, ST_EXC = 5'd17;
   localparam logic [4:0] ST_EXC_JMP = 5'd18;

   logic clk, resert, zero, overflow, div0;
   logic [5:0] opcode, funct;
   logic pcw_v[3], pcwc_v[3], iord_v[3], memwr_v[3], irw_v[3], regw_v[3], m2r_v[3];
   logic epc_v[3], mdc_v[3], whi_v[3], wlo_v[3], busy_v[3];
   logic [1:0] regdst_v[3], srca_v[3], srcb_v[3], exc_v[3];
   logic [2:0] aluc_v[3], pcsrc_v[3];
   logic [4:0] st_v[3];

   int n_tests = 0;
   int n_fail  = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mc_control_unit #(
         .MEM_WAIT((g == 0) ? 1 : ((g == 1) ? 3 : 0)),
         .MD_CYCLES(32),
         .ST_W(5)
      ) u_dut (
         .clk(clk), .resert(resert), .opcode(opcode), .funct(funct),
         .zero(zero), .overflow(overflow), .div0(div0),
         .PCWrite(pcw_v[g]), .PCWriteCond(pcwc_v[g]), .IorD(iord_v[g]),
         .MemWR(memwr_v[g]), .IRWrite(irw_v[g]), .RegWrite(regw_v[g]),
         .MemToReg(m2r_v[g]), .EPCCtrl(epc_v[g]), .MDControl(mdc_v[g]),
         .WriteHI(whi_v[g]), .WriteLO(wlo_v[g]), .RegDst(regdst_v[g]),
         .ALUSrcA(srca_v[g]), .ALUSrcB(srcb_v[g]), .ALUControl(aluc_v[g]),
         .PcSource(pcsrc_v[g]), .Exception(exc_v[g]), .md_busy(busy_v[g]),
         .state_out(st_v[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hold reset two cycles and release on a falling edge; RESET is visible right after.
   task automatic apply_reset();
      resert = 1'b0;
      repeat (2) @(negedge clk);
      resert = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] all_out;
      resert = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0; overflow = 1'b0; div0 = 1'b0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         all_out = {pcw_v[k], pcwc_v[k], iord_v[k], memwr_v[k], irw_v[k], regw_v[k], m2r_v[k],
                    epc_v[k], mdc_v[k], whi_v[k], wlo_v[k], busy_v[k], regdst_v[k], srca_v[k],
                    srcb_v[k], aluc_v[k], pcsrc_v[k], exc_v[k]};
         n_tests++;
         if (all_out !== 32'd0) begin
            n_fail++; $display("FAIL reset_outputs[%0d]: got %h expected 0", k, all_out);
         end
         n_tests++;
         if (st_v[k] !== ST_RESET) begin
            n_fail++; $display("FAIL reset_state[%0d]: got %0d expected %0d", k, st_v[k], ST_RESET);
         end
      end
      resert = 1'b1;
   endtask

   task automatic test_add();
      logic [4:0] exp_st [7];
      exp_st = '{ST_RESET, ST_FETCH, ST_FETCH, ST_DECODE, ST_EXEC_R, ST_WB_R, ST_FETCH};
      apply_reset();
      opcode = 6'h00; funct = 6'h20; overflow = 1'b0;
      for (int i = 0; i < 7; i++) begin
         n_tests++;
         if (st_v[0] !== exp_st[i]) begin
            n_fail++; $display("FAIL add_state[%0d]: got %0d expected %0d", i, st_v[0], exp_st[i]);
         end
         n_tests++;
         if (regw_v[0] !== (i == 5)) begin
            n_fail++; $display("FAIL add_regwrite[%0d]: got %b expected %b", i, regw_v[0], (i == 5));
         end
         n_tests++;
         if (regdst_v[0] !== ((i == 5) ? 2'b01 : 2'b00)) begin
            n_fail++; $display("FAIL add_regdst[%0d]: got %b", i, regdst_v[0]);
         end
         n_tests++;
         if (irw_v[0] !== (i == 2)) begin
            n_fail++; $display("FAIL add_irwrite[%0d]: got %b expected %b", i, irw_v[0], (i == 2));
         end
         if (i == 4) begin
            n_tests++;
            if ({srca_v[0], srcb_v[0], aluc_v[0]} !== {2'b01, 2'b00, 3'b001}) begin
               n_fail++; $display("FAIL add_exec_ctl: got %b_%b_%b expected 01_00_001",
                                  srca_v[0], srcb_v[0], aluc_v[0]);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_lw_sw();
      int n_iord = 0, n_m2r = 0, n_rw = 0, n_mw = 0;
      apply_reset();
      opcode = 6'h23;
      for (int i = 0; i < 13; i++) begin
         if (iord_v[1] === 1'b1) n_iord++;
         if (m2r_v[1] === 1'b1) n_m2r++;
         if (regw_v[1] === 1'b1) n_rw++;
         if (i == 7 || i == 10) begin
            n_tests++;
            if (st_v[1] !== ST_LW_READ) begin
               n_fail++; $display("FAIL lw_read_state[%0d]: got %0d expected %0d", i, st_v[1], ST_LW_READ);
            end
         end
         if (i == 11) begin
            n_tests++;
            if ({st_v[1], m2r_v[1], regw_v[1], regdst_v[1]} !== {ST_LW_WB, 1'b1, 1'b1, 2'b00}) begin
               n_fail++; $display("FAIL lw_wb: got st=%0d m2r=%b rw=%b", st_v[1], m2r_v[1], regw_v[1]);
            end
         end
         if (i == 12) begin
            n_tests++;
            if (st_v[1] !== ST_FETCH) begin
               n_fail++; $display("FAIL lw_return: got %0d expected %0d", st_v[1], ST_FETCH);
            end
         end
         @(negedge clk);
      end
      n_tests++;
      if (n_iord != 4) begin n_fail++; $display("FAIL lw_iord_cycles: got %0d expected 4", n_iord); end
      n_tests++;
      if (n_m2r != 1) begin n_fail++; $display("FAIL lw_memtoreg_cycles: got %0d expected 1", n_m2r); end
      n_tests++;
      if (n_rw != 1) begin n_fail++; $display("FAIL lw_regwrite_cycles: got %0d expected 1", n_rw); end

      apply_reset();
      opcode = 6'h2B;
      n_rw = 0;
      for (int i = 0; i < 12; i++) begin
         if (memwr_v[1] === 1'b1) n_mw++;
         if (regw_v[1] === 1'b1) n_rw++;
         if (i == 7) begin
            n_tests++;
            if ({st_v[1], iord_v[1]} !== {ST_SW_WRITE, 1'b1}) begin
               n_fail++; $display("FAIL sw_state: got %0d iord=%b expected %0d", st_v[1], iord_v[1], ST_SW_WRITE);
            end
         end
         if (i == 11) begin
            n_tests++;
            if (st_v[1] !== ST_FETCH) begin
               n_fail++; $display("FAIL sw_return: got %0d expected %0d", st_v[1], ST_FETCH);
            end
         end
         @(negedge clk);
      end
      n_tests++;
      if (n_mw != 4) begin n_fail++; $display("FAIL sw_memwr_cycles: got %0d expected 4", n_mw); end
      n_tests++;
      if (n_rw != 0) begin n_fail++; $display("FAIL sw_regwrite_cycles: got %0d expected 0", n_rw); end
   endtask

   task automatic test_branch();
      int n_cond = 0;
      apply_reset();
      opcode = 6'h04; zero = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (pcwc_v[2] === 1'b1) n_cond++;
         if (i == 3 || i == 6) begin
            n_tests++;
            if ({st_v[2], pcwc_v[2], pcsrc_v[2], aluc_v[2], srca_v[2], pcw_v[2]} !==
                {ST_BRANCH, 1'b1, 3'b001, 3'b010, 2'b01, 1'b0}) begin
               n_fail++; $display("FAIL branch_ctl[%0d]: got st=%0d pcwc=%b src=%b alu=%b",
                                  i, st_v[2], pcwc_v[2], pcsrc_v[2], aluc_v[2]);
            end
         end
         if (i == 7) begin
            n_tests++;
            if (st_v[2] !== ST_FETCH) begin
               n_fail++; $display("FAIL branch_return: got %0d expected %0d", st_v[2], ST_FETCH);
            end
         end
         if (i == 3) begin
            opcode = 6'h05; zero = 1'b0;
         end
         @(negedge clk);
      end
      n_tests++;
      if (n_cond != 2) begin n_fail++; $display("FAIL branch_cond_cycles: got %0d expected 2", n_cond); end
   endtask

   task automatic test_jump();
      apply_reset();
      opcode = 6'h02; funct = 6'h00;
      for (int i = 0; i < 12; i++) begin
         if (i == 3) begin
            n_tests++;
            if ({st_v[2], pcsrc_v[2], pcw_v[2]} !== {ST_JUMP, 3'b010, 1'b1}) begin
               n_fail++; $display("FAIL jump_ctl: got st=%0d src=%b pcw=%b", st_v[2], pcsrc_v[2], pcw_v[2]);
            end
            opcode = 6'h00; funct = 6'h08;
         end
         if (i == 6) begin
            n_tests++;
            if ({st_v[2], pcsrc_v[2], pcw_v[2]} !== {ST_JR, 3'b011, 1'b1}) begin
               n_fail++; $display("FAIL jr_ctl: got st=%0d src=%b pcw=%b", st_v[2], pcsrc_v[2], pcw_v[2]);
            end
            opcode = 6'h08; funct = 6'h00; overflow = 1'b0;
         end
         if (i == 9) begin
            n_tests++;
            if ({st_v[2], srca_v[2], srcb_v[2], regw_v[2]} !== {ST_EXEC_I, 2'b01, 2'b10, 1'b0}) begin
               n_fail++; $display("FAIL addi_exec: got st=%0d srcb=%b rw=%b", st_v[2], srcb_v[2], regw_v[2]);
            end
         end
         if (i == 10) begin
            n_tests++;
            if ({st_v[2], regdst_v[2], regw_v[2]} !== {ST_WB_I, 2'b00, 1'b1}) begin
               n_fail++; $display("FAIL addi_wb: got st=%0d dst=%b rw=%b", st_v[2], regdst_v[2], regw_v[2]);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_div();
      int n_busy = 0, n_mdc = 0, n_whi = 0, n_wlo = 0;
      apply_reset();
      opcode = 6'h00; funct = 6'h1A; div0 = 1'b0;
      for (int i = 0; i < 39; i++) begin
         if (busy_v[0] === 1'b1) n_busy++;
         if (mdc_v[0] === 1'b1) n_mdc++;
         if (whi_v[0] === 1'b1) n_whi++;
         if (wlo_v[0] === 1'b1) n_wlo++;
         if (i == 4 || i == 5 || i == 36 || i == 37 || i == 38) begin
            n_tests++;
            if (st_v[0] !== ((i == 4) ? ST_MD_START : (i == 37) ? ST_MD_DONE :
                             (i == 38) ? ST_FETCH : ST_MD_RUN)) begin
               n_fail++; $display("FAIL div_state[%0d]: got %0d", i, st_v[0]);
            end
         end
         @(negedge clk);
      end
      n_tests++;
      if (n_busy != 32) begin n_fail++; $display("FAIL div_busy_cycles: got %0d expected 32", n_busy); end
      n_tests++;
      if (n_mdc != 1) begin n_fail++; $display("FAIL div_start_pulse: got %0d expected 1", n_mdc); end
      n_tests++;
      if (n_whi != 1 || n_wlo != 1) begin
         n_fail++; $display("FAIL div_hilo_write: got hi=%0d lo=%0d expected 1/1", n_whi, n_wlo);
      end

      apply_reset();
      div0 = 1'b1; n_whi = 0; n_busy = 0;
      for (int i = 0; i < 8; i++) begin
         if (whi_v[0] === 1'b1) n_whi++;
         if (busy_v[0] === 1'b1) n_busy++;
         if (i == 5) begin
            n_tests++;
            if ({st_v[0], epc_v[0], exc_v[0], aluc_v[0], srcb_v[0]} !== {ST_EXC, 1'b1, 2'b10, 3'b010, 2'b01}) begin
               n_fail++; $display("FAIL div0_exc: got st=%0d epc=%b exc=%b alu=%b",
                                  st_v[0], epc_v[0], exc_v[0], aluc_v[0]);
            end
         end
         if (i == 6) begin
            n_tests++;
            if ({st_v[0], pcsrc_v[0], pcw_v[0], exc_v[0]} !== {ST_EXC_JMP, 3'b100, 1'b1, 2'b10}) begin
               n_fail++; $display("FAIL div0_vector: got st=%0d src=%b pcw=%b exc=%b",
                                  st_v[0], pcsrc_v[0], pcw_v[0], exc_v[0]);
            end
         end
         if (i == 7) begin
            n_tests++;
            if (st_v[0] !== ST_FETCH) begin
               n_fail++; $display("FAIL div0_return: got %0d expected %0d", st_v[0], ST_FETCH);
            end
         end
         @(negedge clk);
      end
      n_tests++;
      if (n_whi != 0 || n_busy != 0) begin
         n_fail++; $display("FAIL div0_no_write: got hi=%0d busy=%0d expected 0/0", n_whi, n_busy);
      end
      div0 = 1'b0;
   endtask

   task automatic test_exceptions();
      int n_rw = 0;
      apply_reset();
      opcode = 6'h00; funct = 6'h20; overflow = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (regw_v[0] === 1'b1) n_rw++;
         if (i == 5) begin
            n_tests++;
            if ({st_v[0], exc_v[0], epc_v[0]} !== {ST_EXC, 2'b01, 1'b1}) begin
               n_fail++; $display("FAIL ovf_exc: got st=%0d exc=%b epc=%b", st_v[0], exc_v[0], epc_v[0]);
            end
         end
         if (i == 6) begin
            n_tests++;
            if ({st_v[0], pcw_v[0], pcsrc_v[0], exc_v[0]} !== {ST_EXC_JMP, 1'b1, 3'b100, 2'b01}) begin
               n_fail++; $display("FAIL ovf_vector: got st=%0d pcw=%b exc=%b", st_v[0], pcw_v[0], exc_v[0]);
            end
         end
         if (i == 7) begin
            n_tests++;
            if (st_v[0] !== ST_FETCH) begin
               n_fail++; $display("FAIL ovf_return: got %0d expected %0d", st_v[0], ST_FETCH);
            end
         end
         @(negedge clk);
      end
      n_tests++;
      if (n_rw != 0) begin n_fail++; $display("FAIL ovf_no_regwrite: got %0d expected 0", n_rw); end
      overflow = 1'b0;

      apply_reset();
      opcode = 6'h3F;
      for (int i = 0; i < 7; i++) begin
         if (i == 4) begin
            n_tests++;
            if ({st_v[0], exc_v[0], epc_v[0]} !== {ST_EXC, 2'b00, 1'b1}) begin
               n_fail++; $display("FAIL invop_exc: got st=%0d exc=%b epc=%b", st_v[0], exc_v[0], epc_v[0]);
            end
         end
         if (i == 5) begin
            n_tests++;
            if ({st_v[0], pcw_v[0], pcsrc_v[0]} !== {ST_EXC_JMP, 1'b1, 3'b100}) begin
               n_fail++; $display("FAIL invop_vector: got st=%0d pcw=%b src=%b", st_v[0], pcw_v[0], pcsrc_v[0]);
            end
         end
         if (i == 6) begin
            n_tests++;
            if (st_v[0] !== ST_FETCH) begin
               n_fail++; $display("FAIL invop_return: got %0d expected %0d", st_v[0], ST_FETCH);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_md_abort();
      int n_busy = 0;
      logic [31:0] all_out;
      apply_reset();
      opcode = 6'h00; funct = 6'h1A; div0 = 1'b0;
      repeat (15) @(negedge clk);
      n_tests++;
      if ({st_v[0], busy_v[0]} !== {ST_MD_RUN, 1'b1}) begin
         n_fail++; $display("FAIL abort_precond: got st=%0d busy=%b", st_v[0], busy_v[0]);
      end
      resert = 1'b0;
      #1;
      all_out = {pcw_v[0], pcwc_v[0], iord_v[0], memwr_v[0], irw_v[0], regw_v[0], m2r_v[0],
                 epc_v[0], mdc_v[0], whi_v[0], wlo_v[0], busy_v[0], regdst_v[0], srca_v[0],
                 srcb_v[0], aluc_v[0], pcsrc_v[0], exc_v[0]};
      n_tests++;
      if ({all_out, st_v[0]} !== {32'd0, ST_RESET}) begin
         n_fail++; $display("FAIL abort_async: got outputs=%h st=%0d expected 0/0", all_out, st_v[0]);
      end
      @(negedge clk);
      resert = 1'b1;
      for (int i = 0; i < 38; i++) begin
         if (busy_v[0] === 1'b1) n_busy++;
         if (i == 1) begin
            n_tests++;
            if (st_v[0] !== ST_FETCH) begin
               n_fail++; $display("FAIL abort_restart: got %0d expected %0d", st_v[0], ST_FETCH);
            end
         end
         if (i == 37) begin
            n_tests++;
            if ({st_v[0], whi_v[0]} !== {ST_MD_DONE, 1'b1}) begin
               n_fail++; $display("FAIL abort_md_done: got st=%0d hi=%b", st_v[0], whi_v[0]);
            end
         end
         @(negedge clk);
      end
      n_tests++;
      if (n_busy != 32) begin n_fail++; $display("FAIL abort_md_count: got %0d expected 32", n_busy); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw_sw();
      test_branch();
      test_jump();
      test_div();
      test_exceptions();
      test_md_abort();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
